reg_read_responder: RTL and testbench
=====================================

# reg_read_responder

Responder side of the decode-stage register read interface. It accepts the two read requests issued by decode and returns the operand values decode consumes as `reg_val_mux_data_1/2`. It holds the 32×32 architectural register file, which write-back updates. It resolves RAW hazards by forwarding from EX, MEM and WB, and it raises a load-use stall request when forwarding cannot supply the value.

## Interface
Parameters:
- DATA_WIDTH, 32, register and operand width
- REG_ADDR_WIDTH, 5, register index width (32 registers)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- read_en_1  in  1  port-1 read request from decode
- read_addr_1  in  5  port-1 register index
- read_en_2  in  1  port-2 read request from decode
- read_addr_2  in  5  port-2 register index
- read_data_1  out  32  port-1 operand to decode
- read_data_2  out  32  port-2 operand to decode
- ex_write_reg_en  in  1  EX-stage instruction will write a register
- ex_write_reg_addr  in  5  EX destination
- ex_write_data  in  32  EX ALU result
- ex_load_flag  in  1  EX instruction is a load, so its data is not yet available
- mem_write_reg_en  in  1  MEM-stage write enable
- mem_write_reg_addr  in  5  MEM destination
- mem_write_data  in  32  MEM result, including load data
- wb_write_reg_en  in  1  write-back enable
- wb_write_reg_addr  in  5  write-back destination
- wb_write_data  in  32  write-back data
- load_stall_request  out  1  load-use hazard; the pipeline holds IF/ID

## Operation
- Storage: 31 writable registers (indices 1–31). Index 0 is not stored and always reads as 0.
- Write: on the rising clk edge, if wb_write_reg_en=1 and wb_write_reg_addr≠0, the register at wb_write_reg_addr takes wb_write_data. Writes to index 0 are dropped.
- Read, per port, combinational, in priority order (first match wins):
  1. rst=0 or read_en=0 → 0.
  2. read_addr=0 → 0.
  3. EX match (ex_write_reg_en=1, ex_write_reg_addr=read_addr):
     - if ex_load_flag=0 → ex_write_data;
     - if ex_load_flag=1 → stored register value, and the port contributes a stall.
  4. MEM match → mem_write_data.
  5. WB match → wb_write_data. This step exists only with the Configuration macro.
  6. Otherwise → stored register value.
- Stall: load_stall_request = (port-1 stall) OR (port-2 stall).
  - Forced 0 while rst=0.
  - A port whose read_en=0, or whose read_addr=0, never stalls.
- Both ports may read the same index in the same cycle; they must return identical data.
- A write-enable asserted with destination 0 never matches any forwarding step.

## Timing
- Reset: asserting rst=0 asynchronously clears all 31 registers to 0. While rst=0, read_data_1, read_data_2 and load_stall_request are all 0.
- Releasing rst is synchronous to clk; the first write takes effect at the first rising edge after release.
- Read latency: 0 cycles. Outputs settle within the same cycle as the address and forwarding inputs.
- Write latency: data written at edge N is readable from storage in cycle N+1.
- Same-cycle write and read of one index:
  - with the macro, the new data is returned via WB forwarding;
  - without it, the old stored value is returned.
- Stall handshake: load_stall_request is level-only, with no acknowledge. It stays asserted every cycle the hazard persists. It drops one cycle later, once the load has moved to MEM and the MEM forward supplies the data.
- Reset asserted mid-write: the write is lost; the register stays 0.

## Configuration
- REGFILE_WB_BYPASS_EN defined:
  - WB forwarding (step 5) is present;
  - decode may read a register in the same cycle it is written back.
- REGFILE_WB_BYPASS_EN undefined:
  - step 5 is removed; reads fall through to storage;
  - the pipeline control guarantees one cycle of separation between write-back and a dependent decode.
- No other behaviour changes.

## Structure
- The shared package/defines hold:
  - DATA_WIDTH and REG_ADDR_WIDTH;
  - REG_NUM=32 and ZERO_REG_ADDR=5'd0;
  - READ_ENABLE/READ_DISABLE and WRITE_ENABLE/WRITE_DISABLE;
  - ZERO_WORD.
- Sub-module `reg_array`: the 31-entry storage with asynchronous active-low clear, one synchronous write port and two combinational read ports.
- The top module holds the forwarding muxes and the stall logic. The per-port forwarding selection is written once and instantiated for each port.

## Test plan
- Reset and write: hold rst=0, then release; write r5=0x12345678 via WB; next cycle read port 1 r5 → 0x12345678. Assert rst=0 → read_data_1=0 immediately, without waiting for a clock edge.
- Zero register: WB writes r0=0xFFFFFFFF; also drive EX destination=0 with data 0xDEAD. Read r0 on both ports → 0 on both, no stall.
- Forward priority: EX r7=0x1, MEM r7=0x2, WB r7=0x3, storage r7=0x4.
  - read r7 → 0x1;
  - drop EX → 0x2;
  - drop MEM → 0x3 with the macro, 0x4 without it.
- Load-use: EX r9 with ex_load_flag=1; port 2 reads r9 → load_stall_request=1. Next cycle the load is in MEM with data 0xCAFE0000 → stall=0 and read_data_2=0xCAFE0000.
- Disabled read: read_en_1=0 with addr r9 while EX is a load to r9 → read_data_1=0, stall=0.
- Dual port: both ports read r3 while MEM is forwarding r3=0xA5A5A5A5 → both outputs 0xA5A5A5A5.

Source files
------------

// File: rtl/reg_read_responder_pkg.sv
// Shared constants and types for the decode-stage register read responder, including the
// per-port forwarding selector. The WB bypass step is present only when REGFILE_WB_BYPASS_EN is defined.
package reg_read_responder_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned REG_NUM        = 32;

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG_ADDR = 5'd0;
    localparam logic                      READ_ENABLE   = 1'b1;
    localparam logic                      READ_DISABLE  = 1'b0;
    localparam logic                      WRITE_ENABLE  = 1'b1;
    localparam logic                      WRITE_DISABLE = 1'b0;
    localparam logic [DATA_WIDTH-1:0]     ZERO_WORD     = '0;

    typedef logic [DATA_WIDTH-1:0]     word_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    // One pipeline stage's pending register write, as seen by the forwarding logic.
    typedef struct packed {
        logic      en;
        reg_addr_t addr;
        word_t     data;
    } fwd_port_t;

    typedef struct packed {
        word_t data;
        logic  stall;
    } fwd_res_t;

    function automatic logic stage_hit(input fwd_port_t stage, input reg_addr_t addr);
        return (stage.en == WRITE_ENABLE) && (stage.addr == addr);
    endfunction

    // Youngest producer wins; a load in EX cannot supply data yet, so the port stalls instead.
    function automatic fwd_res_t fwd_select(
        input logic      rst,
        input logic      en,
        input reg_addr_t addr,
        input word_t     stored,
        input fwd_port_t ex,
        input logic      ex_load,
`ifdef REGFILE_WB_BYPASS_EN
        input fwd_port_t mem,
        input fwd_port_t wb
`else
        input fwd_port_t mem
`endif
    );
        fwd_res_t res;
        res.data  = ZERO_WORD;
        res.stall = 1'b0;
        if (!rst || en == READ_DISABLE || addr == ZERO_REG_ADDR) begin
            res.data = ZERO_WORD;
        end else if (stage_hit(ex, addr)) begin
            res.data  = ex_load ? stored : ex.data;
            res.stall = ex_load;
        end else if (stage_hit(mem, addr)) begin
            res.data = mem.data;
`ifdef REGFILE_WB_BYPASS_EN
        end else if (stage_hit(wb, addr)) begin
            res.data = wb.data;
`endif
        end else begin
            res.data = stored;
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_read_responder_reg_array.sv
// 31-entry architectural register storage (index 0 hard-wired to zero) with asynchronous
// active-low clear, one synchronous write port and two combinational read ports.
module reg_read_responder_reg_array
    import reg_read_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write_en,
    input  logic [REG_ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic [REG_ADDR_WIDTH-1:0] read_addr_1,
    output logic [DATA_WIDTH-1:0]     read_data_1,
    input  logic [REG_ADDR_WIDTH-1:0] read_addr_2,
    output logic [DATA_WIDTH-1:0]     read_data_2
);

    localparam int unsigned NumRegs = 1 << REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [1:NumRegs-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NumRegs; i++) begin
                mem[i] <= '0;
            end
        end else if (write_en == WRITE_ENABLE && write_addr != '0) begin
            mem[write_addr] <= write_data;
        end
    end

    always_comb begin
        read_data_1 = (read_addr_1 == '0) ? '0 : mem[read_addr_1];
        read_data_2 = (read_addr_2 == '0) ? '0 : mem[read_addr_2];
    end

endmodule

// File: rtl/reg_read_responder.sv
// Decode-stage register read responder: register file plus EX/MEM(/WB) forwarding and
// load-use stall request. WB forwarding is enabled by defining REGFILE_WB_BYPASS_EN.
module reg_read_responder
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read_en_1,
    input  logic [REG_ADDR_WIDTH-1:0] read_addr_1,
    input  logic                      read_en_2,
    input  logic [REG_ADDR_WIDTH-1:0] read_addr_2,
    output logic [DATA_WIDTH-1:0]     read_data_1,
    output logic [DATA_WIDTH-1:0]     read_data_2,
    input  logic                      ex_write_reg_en,
    input  logic [REG_ADDR_WIDTH-1:0] ex_write_reg_addr,
    input  logic [DATA_WIDTH-1:0]     ex_write_data,
    input  logic                      ex_load_flag,
    input  logic                      mem_write_reg_en,
    input  logic [REG_ADDR_WIDTH-1:0] mem_write_reg_addr,
    input  logic [DATA_WIDTH-1:0]     mem_write_data,
    input  logic                      wb_write_reg_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_write_reg_addr,
    input  logic [DATA_WIDTH-1:0]     wb_write_data,
    output logic                      load_stall_request
);

    import reg_read_responder_pkg::fwd_port_t;
    import reg_read_responder_pkg::fwd_res_t;
    import reg_read_responder_pkg::fwd_select;

    logic [DATA_WIDTH-1:0] stored_1;
    logic [DATA_WIDTH-1:0] stored_2;
    fwd_port_t             ex_port;
    fwd_port_t             mem_port;
    fwd_res_t              res_1;
    fwd_res_t              res_2;

    reg_read_responder_reg_array #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_reg_array (
        .clk         (clk),
        .rst         (rst),
        .write_en    (wb_write_reg_en),
        .write_addr  (wb_write_reg_addr),
        .write_data  (wb_write_data),
        .read_addr_1 (read_addr_1),
        .read_data_1 (stored_1),
        .read_addr_2 (read_addr_2),
        .read_data_2 (stored_2)
    );

    assign ex_port  = {ex_write_reg_en, ex_write_reg_addr, ex_write_data};
    assign mem_port = {mem_write_reg_en, mem_write_reg_addr, mem_write_data};

`ifdef REGFILE_WB_BYPASS_EN
    fwd_port_t wb_port;
    assign wb_port = {wb_write_reg_en, wb_write_reg_addr, wb_write_data};

    always_comb begin
        res_1 = fwd_select(rst, read_en_1, read_addr_1, stored_1, ex_port, ex_load_flag,
                           mem_port, wb_port);
        res_2 = fwd_select(rst, read_en_2, read_addr_2, stored_2, ex_port, ex_load_flag,
                           mem_port, wb_port);
    end
`else
    always_comb begin
        res_1 = fwd_select(rst, read_en_1, read_addr_1, stored_1, ex_port, ex_load_flag,
                           mem_port);
        res_2 = fwd_select(rst, read_en_2, read_addr_2, stored_2, ex_port, ex_load_flag,
                           mem_port);
    end
`endif

    assign read_data_1        = res_1.data;
    assign read_data_2        = res_2.data;
    assign load_stall_request = res_1.stall | res_2.stall;

endmodule

// File: tb/tb_reg_read_responder.sv
// Self-checking bench for reg_read_responder: directed test-plan scenarios plus randomized
// traffic against a behavioural register-file model. Follows REGFILE_WB_BYPASS_EN.
module tb_reg_read_responder;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit WbBypass = 1'b1;
`else
    localparam bit WbBypass = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        read_en_1, read_en_2;
    logic [4:0]  read_addr_1, read_addr_2;
    logic [31:0] read_data_1, read_data_2;
    logic        ex_write_reg_en, ex_load_flag;
    logic [4:0]  ex_write_reg_addr;
    logic [31:0] ex_write_data;
    logic        mem_write_reg_en;
    logic [4:0]  mem_write_reg_addr;
    logic [31:0] mem_write_data;
    logic        wb_write_reg_en;
    logic [4:0]  wb_write_reg_addr;
    logic [31:0] wb_write_data;
    logic        load_stall_request;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] model_regs [32];

    always #5 clk = ~clk;

    reg_read_responder dut (
        .clk                (clk),
        .rst                (rst),
        .read_en_1          (read_en_1),
        .read_addr_1        (read_addr_1),
        .read_en_2          (read_en_2),
        .read_addr_2        (read_addr_2),
        .read_data_1        (read_data_1),
        .read_data_2        (read_data_2),
        .ex_write_reg_en    (ex_write_reg_en),
        .ex_write_reg_addr  (ex_write_reg_addr),
        .ex_write_data      (ex_write_data),
        .ex_load_flag       (ex_load_flag),
        .mem_write_reg_en   (mem_write_reg_en),
        .mem_write_reg_addr (mem_write_reg_addr),
        .mem_write_data     (mem_write_data),
        .wb_write_reg_en    (wb_write_reg_en),
        .wb_write_reg_addr  (wb_write_reg_addr),
        .wb_write_data      (wb_write_data),
        .load_stall_request (load_stall_request)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural view: the youngest in-flight producer of the register supplies it; an
    // unfinished load cannot, so decode must wait and sees the committed value meanwhile.
    function automatic void model_port(input logic en, input logic [4:0] a,
                                       output logic [31:0] d, output logic st);
        d  = 32'h0;
        st = 1'b0;
        if (rst !== 1'b1 || en !== 1'b1 || a == 5'd0) return;
        if (ex_write_reg_en && ex_write_reg_addr == a) begin
            st = ex_load_flag;
            d  = ex_load_flag ? model_regs[a] : ex_write_data;
        end else if (mem_write_reg_en && mem_write_reg_addr == a) begin
            d = mem_write_data;
        end else if (WbBypass && wb_write_reg_en && wb_write_reg_addr == a) begin
            d = wb_write_data;
        end else begin
            d = model_regs[a];
        end
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] d1, d2;
        logic        s1, s2;
        model_port(read_en_1, read_addr_1, d1, s1);
        model_port(read_en_2, read_addr_2, d2, s2);
        check({tag, ".rd1"}, read_data_1, d1);
        check({tag, ".rd2"}, read_data_2, d2);
        check({tag, ".stall"}, {31'b0, load_stall_request}, {31'b0, s1 | s2});
    endtask

    // Advance through the next rising edge, mirroring the commit into the model.
    task automatic clock_edge();
        @(posedge clk);
        if (rst !== 1'b1) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        end else if (wb_write_reg_en && wb_write_reg_addr != 5'd0) begin
            model_regs[wb_write_reg_addr] = wb_write_data;
        end
        #1;
    endtask

    task automatic idle();
        read_en_1 = 0; read_addr_1 = 0; read_en_2 = 0; read_addr_2 = 0;
        ex_write_reg_en = 0; ex_write_reg_addr = 0; ex_write_data = 0; ex_load_flag = 0;
        mem_write_reg_en = 0; mem_write_reg_addr = 0; mem_write_data = 0;
        wb_write_reg_en = 0; wb_write_reg_addr = 0; wb_write_data = 0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        idle();
        wb_write_reg_en = 1; wb_write_reg_addr = a; wb_write_data = d;
        clock_edge();
        idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        idle();
        rst = 0;
        #2;
        read_en_1 = 1; read_addr_1 = 5; #1;
        check("reset.rd1", read_data_1, 32'h0);
        check("reset.stall", {31'b0, load_stall_request}, 32'h0);
        clock_edge(); clock_edge();
        rst = 1;

        // Reset and write
        wb_write(5'd5, 32'h12345678);
        read_en_1 = 1; read_addr_1 = 5; #1;
        check("wr.r5", read_data_1, 32'h12345678);
        check_model("wr");
        rst = 0; #1;
        check("async_rst.rd1", read_data_1, 32'h0);
        clock_edge();
        rst = 1; #1;
        check("post_rst.r5", read_data_1, 32'h0);

        // Zero register
        idle();
        wb_write_reg_en = 1; wb_write_reg_addr = 0; wb_write_data = 32'hFFFFFFFF;
        ex_write_reg_en = 1; ex_write_reg_addr = 0; ex_write_data = 32'hDEAD;
        read_en_1 = 1; read_addr_1 = 0; read_en_2 = 1; read_addr_2 = 0; #1;
        check("zero.rd1", read_data_1, 32'h0);
        check("zero.rd2", read_data_2, 32'h0);
        check("zero.stall", {31'b0, load_stall_request}, 32'h0);
        clock_edge();
        #1 check("zero.after_wr", read_data_1, 32'h0);

        // Forward priority
        wb_write(5'd7, 32'h4);
        read_en_1 = 1; read_addr_1 = 7;
        ex_write_reg_en = 1; ex_write_reg_addr = 7; ex_write_data = 32'h1;
        mem_write_reg_en = 1; mem_write_reg_addr = 7; mem_write_data = 32'h2;
        wb_write_reg_en = 1; wb_write_reg_addr = 7; wb_write_data = 32'h3; #1;
        check("prio.ex", read_data_1, 32'h1);
        ex_write_reg_en = 0; #1;
        check("prio.mem", read_data_1, 32'h2);
        mem_write_reg_en = 0; #1;
        check("prio.wb", read_data_1, WbBypass ? 32'h3 : 32'h4);
        wb_write_reg_en = 0;
        clock_edge();

        // Load-use
        idle();
        ex_write_reg_en = 1; ex_write_reg_addr = 9; ex_load_flag = 1;
        read_en_2 = 1; read_addr_2 = 9; #1;
        check("load.stall", {31'b0, load_stall_request}, 32'h1);
        check_model("load");
        read_en_1 = 0; read_addr_1 = 9; #1;
        check("dis.rd1", read_data_1, 32'h0);
        read_en_2 = 0; #1;
        check("dis.stall", {31'b0, load_stall_request}, 32'h0);
        read_en_2 = 1;
        clock_edge();
        ex_write_reg_en = 0; ex_load_flag = 0;
        mem_write_reg_en = 1; mem_write_reg_addr = 9; mem_write_data = 32'hCAFE0000; #1;
        check("load.mem.stall", {31'b0, load_stall_request}, 32'h0);
        check("load.mem.rd2", read_data_2, 32'hCAFE0000);

        // Dual port
        idle();
        mem_write_reg_en = 1; mem_write_reg_addr = 3; mem_write_data = 32'hA5A5A5A5;
        read_en_1 = 1; read_addr_1 = 3; read_en_2 = 1; read_addr_2 = 3; #1;
        check("dual.rd1", read_data_1, 32'hA5A5A5A5);
        check("dual.rd2", read_data_2, 32'hA5A5A5A5);
        clock_edge();

        // Randomized traffic over a small address window so hazards are frequent.
        for (int cyc = 0; cyc < 600; cyc++) begin
            read_en_1          = ($urandom_range(0, 7) != 0);
            read_addr_1        = 5'($urandom_range(0, 7));
            read_en_2          = ($urandom_range(0, 7) != 0);
            read_addr_2        = 5'($urandom_range(0, 7));
            ex_write_reg_en    = $urandom_range(0, 1) == 1;
            ex_write_reg_addr  = 5'($urandom_range(0, 7));
            ex_write_data      = $urandom;
            ex_load_flag       = $urandom_range(0, 2) == 0;
            mem_write_reg_en   = $urandom_range(0, 1) == 1;
            mem_write_reg_addr = 5'($urandom_range(0, 7));
            mem_write_data     = $urandom;
            wb_write_reg_en    = $urandom_range(0, 3) != 0;
            wb_write_reg_addr  = 5'($urandom_range(0, 7));
            wb_write_data      = $urandom;
            #1 check_model("rand");
            if ($urandom_range(0, 59) == 0) begin
                rst = 0; #1;
                check_model("rand_rst");
                clock_edge();
                rst = 1;
            end else begin
                clock_edge();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
